// File: rtl/ram_dp_be.sv
// Simple dual-port RAM with per-byte write enables, a hardware clear sequencer,
// selectable read-during-write behaviour and an optional output register.
module ram_dp_be #(
  parameter int DATA_WIDTH = 32,  // must be a multiple of 8
  parameter int ADDR_WIDTH = 6,
  parameter int RDW_MODE   = 0,   // 0: same-address read sees new data, 1: old data
  parameter int OUT_REG    = 0    // 1: extra register stage on the read path
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  output logic                    busy,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_clr_cnt;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic                    r_rd_vld1;
  logic [DATA_WIDTH-1:0]   r_rd_dat1;

  logic                    w_clearing;
  logic                    w_wr_ok;
  logic                    w_rd_ok;
  logic [DATA_WIDTH-1:0]   w_rd_old;
  logic [DATA_WIDTH-1:0]   w_rd_word;

  assign w_clearing = (r_state == S_CLEAR);
  assign busy       = w_clearing;
  assign w_wr_ok    = !w_clearing && wr_en;
  assign w_rd_ok    = !w_clearing && rd_en;

  // Clear sequencer: reset parks it in CLEAR so every power-up zeroes the array.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (clr) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
          end
        end
        S_CLEAR: begin
          // clr is deliberately not examined here: a clear never restarts.
          if (r_clr_cnt == LAST_ADDR) begin
            r_state <= S_IDLE;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

  // NOTE: the array has no reset branch; a reset on a memory prevents RAM
  // inference. The clear sequencer is the only way to zero it.
  always_ff @(posedge clk) begin
    if (w_clearing) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (wr_be[i]) begin
          r_mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  assign w_rd_old = r_mem[rd_addr];

  // Same-address bypass merges the enabled write lanes into the returned word.
  // NOTE: w_rd_word gets a full default before any conditional update so the
  // block can never infer a latch.
  always_comb begin
    w_rd_word = w_rd_old;
    if ((RDW_MODE == 0) && w_wr_ok && (wr_addr == rd_addr)) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (wr_be[i]) begin
          w_rd_word[8*i +: 8] = wr_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_vld1 <= 1'b0;
      r_rd_dat1 <= '0;
    end else begin
      r_rd_vld1 <= w_rd_ok;
      if (w_rd_ok) begin
        r_rd_dat1 <= w_rd_word;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  r_rd_vld2;
      logic [DATA_WIDTH-1:0] r_rd_dat2;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rd_vld2 <= 1'b0;
          r_rd_dat2 <= '0;
        end else begin
          r_rd_vld2 <= r_rd_vld1;
          if (r_rd_vld1) begin
            r_rd_dat2 <= r_rd_dat1;
          end
        end
      end

      assign rd_valid = r_rd_vld2;
      assign rd_data  = r_rd_dat2;
    end else begin : g_no_out_reg
      assign rd_valid = r_rd_vld1;
      assign rd_data  = r_rd_dat1;
    end
  endgenerate

endmodule
